// File: rtl/riscv_pkg.sv
// Shared types for the fetch sequencer: FSM state, redirect source encoding
// and the fixed instruction size.
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_BR   = 2'd1,
    REDIR_MRET = 2'd2,
    REDIR_TRAP = 2'd3
  } redir_src_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_fetch_ctrl_redir_sel.sv
// Redirect priority mux (trap > mret > branch) with 4-byte alignment check
// on the branch and mret targets; trap vectors are forced aligned.
module redir_sel
  import riscv_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             br_taken,
  input  logic [Width-1:0] br_target,
  input  logic             trap,
  input  logic [Width-1:0] trap_vec,
  input  logic             mret,
  input  logic [Width-1:0] mepc,
  output logic             redir,
  output logic             redir_ok,
  output logic [Width-1:0] target,
  output logic             misalign_d,
  output redir_src_e       src
);

  always_comb begin
    src    = REDIR_NONE;
    target = br_target;
    if (trap) begin
      src    = REDIR_TRAP;
      target = {trap_vec[Width-1:2], 2'b00};
    end else if (mret) begin
      src    = REDIR_MRET;
      target = mepc;
    end else if (br_taken) begin
      src    = REDIR_BR;
      target = br_target;
    end
  end

  assign redir      = trap | mret | br_taken;
  assign misalign_d = ((src == REDIR_MRET) || (src == REDIR_BR)) && (target[1:0] != 2'b00);
  assign redir_ok   = redir & ~misalign_d;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer: drives pc_next every cycle, runs the single-outstanding
// imem req/gnt/rvalid handshake, applies redirects and debug halt/resume.
module pc_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int               Width     = 32,
  parameter logic [Width-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] pc,
  output logic [Width-1:0] pc_next,
  output logic             imem_req,
  output logic [Width-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  output logic             instr_valid,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [Width-1:0] br_target,
  input  logic             trap,
  input  logic [Width-1:0] trap_vec,
  input  logic             mret,
  input  logic [Width-1:0] mepc,
  input  logic             halt_req,
  input  logic             resume,
  output logic             halted,
  output logic             misalign
);

  state_e           state_q, state_d;
  logic             pend_vld_q, pend_vld_d;
  logic [Width-1:0] pend_pc_q, pend_pc_d;
  logic             misalign_q;

  logic             redir, redir_ok, misalign_d;
  logic [Width-1:0] target;
  redir_src_e       src;

  redir_sel #(.Width(Width)) u_redir_sel (
    .br_taken   (br_taken),
    .br_target  (br_target),
    .trap       (trap),
    .trap_vec   (trap_vec),
    .mret       (mret),
    .mepc       (mepc),
    .redir      (redir),
    .redir_ok   (redir_ok),
    .target     (target),
    .misalign_d (misalign_d),
    .src        (src)
  );

  always_comb begin
    state_d     = state_q;
    pc_next     = pc;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pend_vld_d  = pend_vld_q;
    pend_pc_d   = pend_pc_q;
    case (state_q)
      BOOT: begin
        pc_next = RESET_VEC;
        state_d = REQ;
      end
      REQ: begin
        imem_req = ~stall & ~redir;
        if (redir_ok) begin
          pc_next = target;
        end else if (imem_gnt && imem_req) begin
          state_d = WAIT;
        end else if (halt_req && !stall) begin
          state_d = HALT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d    = REQ;
          pend_vld_d = 1'b0;
          // A redirect seen while the fetch was in flight kills the returned word.
          if (redir_ok) begin
            pc_next = target;
          end else if (pend_vld_q) begin
            pc_next = pend_pc_q;
          end else begin
            instr_valid = 1'b1;
            pc_next     = pc + Width'(INSTR_BYTES);
          end
        end else if (redir_ok) begin
          pend_pc_d  = target;
          pend_vld_d = 1'b1;
        end
      end
      HALT: begin
        if (src == REDIR_TRAP) begin
          pc_next = target;
          state_d = REQ;
        end else if (resume) begin
          state_d = REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pend_vld_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      misalign_q <= misalign_d & ((state_q == REQ) || (state_q == WAIT));
    end
  end

  always_ff @(posedge clk) begin
    pend_pc_q <= pend_pc_d;
  end

  assign imem_addr = pc;
  assign halted    = (state_q == HALT);
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench: PC register model around pc_fetch_ctrl, hand-driven
// imem handshake, redirects, misalign, halt/resume and async reset.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid, instr_valid, stall;
  logic        br_taken, trap, mret, halt_req, resume, halted, misalign;
  logic [31:0] br_target, trap_vec, mepc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= 32'h0;
    else          pc <= pc_next;
  end

  pc_fetch_ctrl #(.Width(32), .RESET_VEC(32'h0000_0100)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc          (pc),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .instr_valid (instr_valid),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .trap        (trap),
    .trap_vec    (trap_vec),
    .mret        (mret),
    .mepc        (mepc),
    .halt_req    (halt_req),
    .resume      (resume),
    .halted      (halted),
    .misalign    (misalign)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; stall = 0;
    br_taken = 0; trap = 0; mret = 0; halt_req = 0; resume = 0;
    br_target = 0; trap_vec = 0; mepc = 0;
    repeat (3) tick();
    check_vec("rst_req", 32'(imem_req), 32'd0);
    check_vec("rst_ivld", 32'(instr_valid), 32'd0);
    check_vec("rst_halted", 32'(halted), 32'd0);
    check_vec("rst_misalign", 32'(misalign), 32'd0);

    reset_n = 1'b1;
    settle();
    check_vec("boot_pc_next", pc_next, 32'h100);
    check_vec("boot_req", 32'(imem_req), 32'd0);

    tick(); imem_gnt = 1; settle();
    check_vec("req0_req", 32'(imem_req), 32'd1);
    check_vec("req0_addr", imem_addr, 32'h100);
    tick(); imem_gnt = 0; settle();
    check_vec("wait0_req", 32'(imem_req), 32'd0);
    check_vec("wait0_ivld", 32'(instr_valid), 32'd0);
    tick(); imem_rvalid = 1; settle();
    check_vec("rv0_ivld", 32'(instr_valid), 32'd1);
    check_vec("rv0_pc_next", pc_next, 32'h104);
    tick(); imem_rvalid = 0; imem_gnt = 1; settle();
    check_vec("req1_addr", imem_addr, 32'h104);
    check_vec("req1_req", 32'(imem_req), 32'd1);

    // branch while fetch in flight, then rvalid kills it
    tick(); imem_gnt = 0; br_taken = 1; br_target = 32'h200; settle();
    check_vec("pend_hold", pc_next, 32'h104);
    check_vec("pend_ivld", 32'(instr_valid), 32'd0);
    tick(); br_taken = 0; imem_rvalid = 1; settle();
    check_vec("kill_ivld", 32'(instr_valid), 32'd0);
    check_vec("kill_pc_next", pc_next, 32'h200);
    tick(); imem_rvalid = 0; settle();
    check_vec("req2_addr", imem_addr, 32'h200);
    check_vec("req2_req", 32'(imem_req), 32'd1);

    // misaligned branch is dropped
    br_taken = 1; br_target = 32'h202; settle();
    check_vec("mis_req", 32'(imem_req), 32'd0);
    check_vec("mis_pc_next", pc_next, 32'h200);
    check_vec("mis_early", 32'(misalign), 32'd0);
    tick(); br_taken = 0; settle();
    check_vec("mis_pulse", 32'(misalign), 32'd1);
    check_vec("mis_pc", imem_addr, 32'h200);
    tick(); settle();
    check_vec("mis_clear", 32'(misalign), 32'd0);

    // trap beats branch, trap vector forced aligned
    trap = 1; trap_vec = 32'h83; br_taken = 1; br_target = 32'h300; settle();
    check_vec("trap_req", 32'(imem_req), 32'd0);
    check_vec("trap_pc_next", pc_next, 32'h80);
    tick(); trap = 0; br_taken = 0; settle();
    check_vec("trap_misalign", 32'(misalign), 32'd0);
    check_vec("trap_addr", imem_addr, 32'h80);

    // sequential wrap
    br_taken = 1; br_target = 32'hFFFF_FFFC; settle();
    check_vec("wrap_redir", pc_next, 32'hFFFF_FFFC);
    tick(); br_taken = 0; imem_gnt = 1; settle();
    check_vec("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); imem_gnt = 0; imem_rvalid = 1; settle();
    check_vec("wrap_ivld", 32'(instr_valid), 32'd1);
    check_vec("wrap_pc_next", pc_next, 32'h0);

    // halt / resume
    tick(); imem_rvalid = 0; halt_req = 1; settle();
    check_vec("hreq_req", 32'(imem_req), 32'd1);
    check_vec("hreq_halted", 32'(halted), 32'd0);
    tick(); halt_req = 0; br_taken = 1; br_target = 32'h400; settle();
    check_vec("halt_halted", 32'(halted), 32'd1);
    check_vec("halt_req_o", 32'(imem_req), 32'd0);
    check_vec("halt_br_ign", pc_next, 32'h0);
    tick(); br_taken = 0; resume = 1; settle();
    check_vec("halt_stay", 32'(halted), 32'd1);
    tick(); resume = 0; settle();
    check_vec("resume_halted", 32'(halted), 32'd0);
    check_vec("resume_req", 32'(imem_req), 32'd1);
    check_vec("resume_addr", imem_addr, 32'h0);

    // trap out of HALT wins over resume
    halt_req = 1;
    tick(); halt_req = 0; trap = 1; trap_vec = 32'h40; resume = 1; settle();
    check_vec("htrap_halted", 32'(halted), 32'd1);
    check_vec("htrap_pc_next", pc_next, 32'h40);
    tick(); trap = 0; resume = 0; settle();
    check_vec("htrap_exit", 32'(halted), 32'd0);
    check_vec("htrap_addr", imem_addr, 32'h40);

    // async reset in the middle of HALT
    halt_req = 1;
    tick(); halt_req = 0; settle();
    check_vec("h2_halted", 32'(halted), 32'd1);
    reset_n = 1'b0; #1;
    check_vec("arst_halted", 32'(halted), 32'd0);
    check_vec("arst_pc_next", pc_next, 32'h100);
    check_vec("arst_req", 32'(imem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
